// File: rtl/segway_pkg.sv
// Shared definitions for the Segway BLE authorization path.
//   CMD_GO / CMD_STOP : command bytes sent by the phone app over BLE UART
//   auth_state_t      : authorization FSM states (OFF, PWRD, STOP)
//   rx_state_t        : UART receiver states (IDLE, START, DATA, STOP_BIT)
package segway_pkg;

    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
    localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        PWRD = 2'd1,
        STOP = 2'd2
    } auth_state_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        DATA     = 2'd2,
        STOP_BIT = 2'd3
    } rx_state_t;

    // Balance control stays enabled while stopping: the rider must step off
    // before power is actually removed.
    function automatic logic is_powered(input auth_state_t s);
        return (s != OFF);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with start-bit glitch rejection.
//   clk, rst_n : system clock, async active-low reset
//   RX         : serial input, idle high, asynchronous to clk
//   rx_data    : received byte, valid while rdy is high
//   rdy        : one-cycle pulse, byte received with a good stop bit
//   frm_err    : one-cycle pulse, stop bit sampled low (byte dropped)
module uart_rx
    import segway_pkg::*;
#(
    parameter int BAUD_CNT = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int            CW   = $clog2(BAUD_CNT + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_CNT / 2 - 1);

    logic          rx_ff1, rx_s, rx_s_d;
    rx_state_t     state, nxt;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          cnt_clr, sample, rdy_nxt, ferr_nxt;
    logic          rx_fall;

    // Synchronizer and edge-detect flops preset high so reset release on an
    // idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1 <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_ff1 <= RX;
            rx_s   <= rx_ff1;
            rx_s_d <= rx_s;
        end
    end

    assign rx_fall = rx_s_d & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        cnt_clr  = 1'b0;
        sample   = 1'b0;
        rdy_nxt  = 1'b0;
        ferr_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    nxt     = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (baud_cnt == HALF) begin
                    cnt_clr = 1'b1;
                    nxt     = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == FULL) begin
                    cnt_clr = 1'b1;
                    sample  = 1'b1;
                    if (bit_cnt == 4'd8) begin
                        if (rx_s) begin
                            rdy_nxt = 1'b1;
                            nxt     = IDLE;
                        end else begin
                            ferr_nxt = 1'b1;
                            nxt      = STOP_BIT;
                        end
                    end
                end
            end
            STOP_BIT: begin
                // Hold off after a framing error until the line idles high,
                // otherwise a stuck-low line would retrigger frames.
                if (rx_s) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            if (cnt_clr || state == IDLE || state == STOP_BIT)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state != DATA) bit_cnt <= '0;
            else if (sample)   bit_cnt <= bit_cnt + 4'd1;

            if (sample) shreg <= {rx_s, shreg[8:1]};

            // On the stop-bit sample the 8 data bits sit in shreg[8:1].
            if (rdy_nxt) rx_data <= shreg[8:1];

            rdy     <= rdy_nxt;
            frm_err <= ferr_nxt;
        end
    end

endmodule

// File: rtl/ble_auth.sv
// BLE authorization for the Segway: enables balance control on 'G', and
// disables it on 'S' once the rider is off the platform.
//   clk, rst_n : system clock, async active-low reset
//   RX         : serial command line from the BLE module
//   rider_off  : load cells report no rider (synchronous to clk)
//   pwr_up     : registered enable for downstream balance control
//   frm_err    : registered one-cycle pulse on a UART framing error
module ble_auth
    import segway_pkg::*;
#(
    parameter int BAUD_CNT = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX,
    input  logic rider_off,
    output logic pwr_up,
    output logic frm_err
);

    logic [7:0]  rx_data;
    logic        rdy;
    auth_state_t state, nxt;

    uart_rx #(.BAUD_CNT(BAUD_CNT)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= OFF;
            pwr_up <= 1'b0;
        end else begin
            state  <= nxt;
            pwr_up <= is_powered(nxt);
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            OFF: begin
                if (rdy && rx_data == CMD_GO) nxt = PWRD;
            end
            PWRD: begin
                if (rdy && rx_data == CMD_STOP) nxt = rider_off ? OFF : STOP;
            end
            STOP: begin
                // A fresh 'G' overrides the rider stepping off in the same cycle.
                if (rdy && rx_data == CMD_GO) nxt = PWRD;
                else if (rider_off)           nxt = OFF;
            end
            default: nxt = OFF;
        endcase
    end

endmodule

// File: tb/tb_ble_auth.sv
module tb_ble_auth;

    localparam int B = 32;  // shortened bit time keeps the run small

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RX = 1'b1;
    logic rider_off = 1'b0;
    logic pwr_up, frm_err;

    ble_auth #(.BAUD_CNT(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observation counters, updated away from the active edge
    int cyc = 0;
    int rdy_cnt = 0, rdy_cyc = -1, rise_cyc = -1;
    int ferr_pulses = 0, ferr_long = 0;
    int last_start_cyc = 0;
    logic pwr_prev = 1'b0, ferr_prev = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (dut.u_rx.rdy) begin
            rdy_cnt = rdy_cnt + 1;
            rdy_cyc = cyc;
        end
        if (pwr_up && !pwr_prev) rise_cyc = cyc;
        pwr_prev = pwr_up;
        if (frm_err && !ferr_prev) ferr_pulses = ferr_pulses + 1;
        if (frm_err && ferr_prev)  ferr_long = ferr_long + 1;
        ferr_prev = frm_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        RX = 1'b1;
        rider_off = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Sends one 8N1 frame; optionally raises rider_off in the rdy cycle.
    task automatic send_byte(input logic [7:0] d, input logic stop_ok,
                             input int gap, input bit raise_at_rdy);
        logic [9:0] bits;
        bits = {stop_ok, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = bits[i];
            if (i == 0) last_start_cyc = cyc;
            for (int c = 0; c < B; c++) begin
                @(negedge clk);
                if (raise_at_rdy && dut.u_rx.rdy) rider_off = 1'b1;
            end
        end
        RX = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Reference model: command rules expressed as modes.
    localparam int M_OFF = 0, M_RUN = 1, M_HALT = 2;

    function automatic int next_mode(input int m, input logic [7:0] d, input logic r);
        if (m == M_OFF)  return (d == 8'h47) ? M_RUN : M_OFF;
        if (m == M_RUN)  return (d == 8'h53) ? (r ? M_OFF : M_HALT) : M_RUN;
        if (d == 8'h47)  return M_RUN;
        return r ? M_OFF : M_HALT;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       rider;
        logic       stop_ok;
        logic       exp_pwr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int f0, r0, m, gap, sel;
        logic [7:0] d;
        logic r, ok;

        vecs[0]  = '{8'h47, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{8'h53, 1'b0, 1'b1, 1'b1, 1'b0};  // stop, rider on
        vecs[2]  = '{8'h47, 1'b0, 1'b1, 1'b1, 1'b0};  // back to powered
        vecs[3]  = '{8'h53, 1'b1, 1'b1, 1'b0, 1'b0};  // stop, rider off
        vecs[4]  = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'h53, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b1};  // bad stop bit
        vecs[7]  = '{8'h47, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{8'h47, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{8'h53, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{8'h47, 1'b1, 1'b1, 1'b1, 1'b0};  // rider leaves, then G
        vecs[12] = '{8'h53, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{8'h53, 1'b0, 1'b0, 1'b0, 1'b1};

        // reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset pwr_up", pwr_up, 0);
        check("reset frm_err", frm_err, 0);
        check("reset rdy", dut.u_rx.rdy, 0);
        do_reset();
        check("post-reset pwr_up", pwr_up, 0);
        check("post-reset no rdy", rdy_cnt, 0);

        // 'G' timing: rdy near 9.5 bits after the start edge, pwr_up one clk later
        rdy_cyc = -1;
        send_byte(8'h47, 1'b1, 2 * B, 1'b0);
        check("G rdy window", (rdy_cyc - last_start_cyc >= 9 * B) &&
                              (rdy_cyc - last_start_cyc <= 10 * B), 1);
        check("G rdy->pwr_up latency", rise_cyc - rdy_cyc, 1);
        check("G pwr_up", pwr_up, 1);

        // 'S' with rider on keeps power; rider stepping off drops it next clk
        send_byte(8'h53, 1'b1, 2 * B, 1'b0);
        check("S rider on pwr_up", pwr_up, 1);
        rider_off = 1'b1;
        @(negedge clk);
        check("rider off next clk", pwr_up, 0);
        rider_off = 1'b0;

        // table vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 14; i++) begin
            rider_off = vecs[i].rider;
            f0 = ferr_pulses;
            send_byte(vecs[i].data, vecs[i].stop_ok, 2 * B, 1'b0);
            check($sformatf("vec%0d pwr_up", i), pwr_up, vecs[i].exp_pwr);
            check($sformatf("vec%0d frm_err", i), ferr_pulses - f0, vecs[i].exp_ferr);
        end
        rider_off = 1'b0;

        // 'G' arriving in the same cycle rider_off rises while stopping
        do_reset();
        send_byte(8'h47, 1'b1, 2 * B, 1'b0);
        send_byte(8'h53, 1'b1, 2 * B, 1'b0);
        send_byte(8'h47, 1'b1, 2 * B, 1'b1);
        check("G wins rider_off raised", rider_off, 1);
        check("G wins pwr_up", pwr_up, 1);
        repeat (5) @(negedge clk);
        check("G wins pwr_up held", pwr_up, 1);
        rider_off = 1'b0;

        // back-to-back frames with no idle gap
        do_reset();
        r0 = rdy_cnt;
        send_byte(8'h53, 1'b1, 0, 1'b0);
        send_byte(8'h47, 1'b1, 2 * B, 1'b0);
        check("b2b byte count", rdy_cnt - r0, 2);
        check("b2b pwr_up", pwr_up, 1);

        // short low glitch while idle
        do_reset();
        r0 = rdy_cnt;
        f0 = ferr_pulses;
        RX = 1'b0;
        repeat (8) @(negedge clk);
        RX = 1'b1;
        repeat (12 * B) @(negedge clk);
        check("glitch no rdy", rdy_cnt - r0, 0);
        check("glitch no frm_err", ferr_pulses - f0, 0);
        check("glitch pwr_up", pwr_up, 0);

        // reset in the middle of a 'G' frame
        do_reset();
        fork
            send_byte(8'h47, 1'b1, 2 * B, 1'b0);
            begin
                repeat (4 * B) @(negedge clk);
                rst_n = 1'b0;
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (4 * B) @(negedge clk);
        check("reset mid-frame pwr_up", pwr_up, 0);

        // randomized frames against the reference model
        do_reset();
        m = M_OFF;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            d   = (sel == 0) ? 8'h47 : (sel == 1) ? 8'h53 : 8'($urandom_range(0, 255));
            r   = ($urandom_range(0, 2) == 0);
            ok  = ($urandom_range(0, 7) != 0);
            gap = ok ? $urandom_range(0, B) : B + $urandom_range(0, B);
            rider_off = r;
            if (m == M_HALT && r) m = M_OFF;
            if (ok) m = next_mode(m, d, r);
            f0 = ferr_pulses;
            send_byte(d, ok, gap, 1'b0);
            check($sformatf("rand%0d pwr_up d=%02h", n, d), pwr_up, (m != M_OFF));
            check($sformatf("rand%0d frm_err", n), ferr_pulses - f0, {31'd0, !ok});
        end
        repeat (B) @(negedge clk);

        check("frm_err single-cycle", ferr_long, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ble_auth.md
BLE_AUTH -- requirements
Module: ble_auth

Interface
REQ-001 BAUD_CNT, default 2604, clk cycles per UART bit (50 MHz / 19200 baud).
REQ-002 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 RX  input  1  serial command line from BLE module, idle high, 8N1, LSB first, asynchronous to clk.
REQ-005 rider_off  input  1  high when load cells report no rider; synchronous to clk.
REQ-006 pwr_up  output  1  registered; high enables balance control downstream.
REQ-007 frm_err  output  1  registered one-cycle pulse on a framing error.

Function
REQ-008 RX SHALL pass through two flops before any use; the metastability-safe sample is rx_s.
REQ-009 Receiver SHALL start a frame on a falling edge of rx_s while idle.
REQ-010 Receiver SHALL wait BAUD_CNT/2 cycles to mid start bit, then sample 9 further bits every BAUD_CNT cycles (8 data, 1 stop).
REQ-011 Receiver SHALL check the start bit at mid-bit; if rx_s is high there, it SHALL abandon the frame and return to idle with no rdy and no frm_err (glitch rejection).
REQ-012 Stop bit high: receiver SHALL assert internal rdy for exactly one cycle with the 8-bit byte, then return to idle.
REQ-013 Stop bit low: receiver SHALL discard the byte, pulse frm_err one cycle, and return to idle only after rx_s is seen high.
REQ-014 Baud counter SHALL be wide enough for BAUD_CNT; bit counter 4 bits; shift register 9 bits, shift-right.
REQ-015 Auth FSM states: OFF, PWRD, STOP; pwr_up = 1 in PWRD and STOP, 0 in OFF.
REQ-016 OFF: byte 0x47 ('G') -> PWRD; all other bytes ignored.
REQ-017 PWRD: 0x53 ('S') with rider_off=1 -> OFF; 0x53 with rider_off=0 -> STOP; other bytes ignored.
REQ-018 STOP: rider_off=1 -> OFF; 0x47 -> PWRD; 0x47 and rider_off=1 in the same cycle -> PWRD (G wins).
REQ-019 FSM SHALL act only in the rdy cycle for byte decisions; rider_off in STOP is evaluated every cycle.
REQ-020 pwr_up SHALL change on the clk edge after rdy (one-cycle latency from rdy).
REQ-021 A new start edge arriving in the rdy cycle SHALL be accepted without loss (back-to-back bytes).

Reset
REQ-022 rst_n low SHALL asynchronously set: FSM OFF, pwr_up 0, frm_err 0, rdy 0, receiver idle, counters 0.
REQ-023 RX synchronizer flops SHALL preset to 1 so reset release raises no false start.
REQ-024 Reset mid-frame SHALL abort the frame; the partial byte SHALL never reach the FSM.

Structure
REQ-025 Shared package segway_pkg SHALL hold CMD_GO=8'h47, CMD_STOP=8'h53, the auth state enum, and the rx state enum (IDLE, START, DATA, STOP_BIT).
REQ-026 Receiver SHALL be sub-module uart_rx (clk, rst_n, RX, rx_data[7:0], rdy, frm_err), parameterized by BAUD_CNT; ble_auth holds only the FSM and the instance.

Verification
REQ-027 Reset, then send 0x47 at 19200 baud -> pwr_up rises 1 clk after rdy, about 9.5*2604 clks after the start edge.
REQ-028 pwr_up=1, rider_off=0, send 0x53 -> pwr_up stays 1 (STOP); then rider_off=1 -> pwr_up 0 on the next clk.
REQ-029 pwr_up=1, rider_off=1, send 0x53 -> pwr_up falls 1 clk after rdy.
REQ-030 OFF, send 0x41 then 0x53 -> pwr_up stays 0 throughout; back-to-back 0x53 then 0x47 frames with no idle gap -> pwr_up=1.
REQ-031 Send 0x47 with stop bit forced low -> frm_err pulses 1 cycle, pwr_up stays 0; a following valid 0x47 -> pwr_up=1.
REQ-032 Low RX glitch of 500 clks while idle -> no rdy, no frm_err; rst_n low mid-frame during 0x47 -> pwr_up stays 0 after release.
